// File: rtl/iec_sd_arbiter_if.sv
// Host-side SD block interface shared by the drive arbiter and the SD host.
// The master drives the request; the slave acknowledges and moves data.
interface iec_sd_arbiter_if;
  logic [31:0] sd_lba;
  logic [5:0]  sd_sz;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  modport master (
    output sd_lba, sd_sz, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_sz, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_wr
  );
endinterface

// File: rtl/iec_sd_arbiter.sv
// Round-robin arbiter that shares one SD block interface between up to four
// IEC drive channels, routing ack/buffer strobes back to the granted channel.
module iec_sd_arbiter #(
  parameter int         NDRIVES        = 4,
  parameter logic [3:0] LBA_SHIFT_MASK = 4'b0000
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [NDRIVES-1:0]     ch_en,
  input  logic [NDRIVES*32-1:0]  ch_lba,
  input  logic [NDRIVES*6-1:0]   ch_sz,
  input  logic [NDRIVES-1:0]     ch_rd,
  input  logic [NDRIVES-1:0]     ch_wr,
  output logic [NDRIVES-1:0]     ch_ack,
  output logic [NDRIVES-1:0]     ch_buff_wr,
  input  logic [NDRIVES*8-1:0]   ch_buff_din,
  iec_sd_arbiter_if.master       sd,
  output logic [1:0]             grant,
  output logic                   busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [31:0] lba_q, lba_d;
  logic [5:0]  sz_q, sz_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

  logic [NDRIVES-1:0] eligible;
  logic               pick_found;
  logic [1:0]         pick_idx;
  logic [31:0]        pick_lba;
  logic [5:0]         pick_sz;
  logic               pick_rd;
  logic               grant_req;
  logic               route_en;
  logic [7:0]         buff_din;

  assign eligible = ch_en & (ch_rd | ch_wr);

  // Two passes give the rotation: channels above last_grant first, then the rest.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    pick_lba   = 32'd0;
    pick_sz    = 6'd0;
    pick_rd    = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NDRIVES; i++) begin
        if (!pick_found && eligible[i] &&
            ((p == 0) ? (2'(i) > last_grant_q) : (2'(i) <= last_grant_q))) begin
          pick_found = 1'b1;
          pick_idx   = 2'(i);
          pick_rd    = ch_rd[i];
          pick_sz    = ch_sz[i*6 +: 6];
          pick_lba   = LBA_SHIFT_MASK[i] ? {ch_lba[i*32 +: 31], 1'b0}
                                         : ch_lba[i*32 +: 32];
        end
      end
    end
  end

  assign route_en = (state_q == ST_REQ) || (state_q == ST_XFER);

  always_comb begin
    ch_ack     = '0;
    ch_buff_wr = '0;
    buff_din   = 8'd0;
    grant_req  = 1'b0;
    for (int i = 0; i < NDRIVES; i++) begin
      if (grant_q == 2'(i)) begin
        grant_req = ch_rd[i] | ch_wr[i];
        if (route_en) begin
          ch_ack[i]     = sd.sd_ack;
          ch_buff_wr[i] = sd.sd_buff_wr;
          buff_din      = ch_buff_din[i*8 +: 8];
        end
      end
    end
  end

  // Simultaneous read and write on one channel resolves to a read.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    lba_d        = lba_q;
    sz_d         = sz_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_REQ;
          grant_d = pick_idx;
          lba_d   = pick_lba;
          sz_d    = pick_sz;
          rd_d    = pick_rd;
          wr_d    = ~pick_rd;
        end
      end
      ST_REQ: begin
        if (sd.sd_ack) begin
          state_d = ST_XFER;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else if (!grant_req) begin
          state_d = ST_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      ST_XFER: begin
        if (!sd.sd_ack) begin
          state_d      = ST_REL;
          last_grant_d = grant_q;
        end
      end
      ST_REL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'(NDRIVES - 1);
      lba_q        <= 32'd0;
      sz_q         <= 6'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      lba_q        <= lba_d;
      sz_q         <= sz_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  assign sd.sd_lba      = lba_q;
  assign sd.sd_sz       = sz_q;
  assign sd.sd_rd       = rd_q;
  assign sd.sd_wr       = wr_q;
  assign sd.sd_buff_din = buff_din;
  assign grant          = grant_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Directed self-checking bench for iec_sd_arbiter; channel 2 has its LBA shifted
// so the shift path and the unshifted path are exercised by one instance.
module tb_iec_sd_arbiter;

  logic         clk_sys;
  logic         reset_n;
  logic [3:0]   ch_en;
  logic [127:0] ch_lba;
  logic [23:0]  ch_sz;
  logic [3:0]   ch_rd;
  logic [3:0]   ch_wr;
  logic [3:0]   ch_ack;
  logic [3:0]   ch_buff_wr;
  logic [31:0]  ch_buff_din;
  logic [1:0]   grant;
  logic         busy;

  int tests_run;
  int tests_failed;

  iec_sd_arbiter_if sd_bus ();

  iec_sd_arbiter #(
    .NDRIVES        (4),
    .LBA_SHIFT_MASK (4'b0100)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ch_en       (ch_en),
    .ch_lba      (ch_lba),
    .ch_sz       (ch_sz),
    .ch_rd       (ch_rd),
    .ch_wr       (ch_wr),
    .ch_ack      (ch_ack),
    .ch_buff_wr  (ch_buff_wr),
    .ch_buff_din (ch_buff_din),
    .sd          (sd_bus.master),
    .grant       (grant),
    .busy        (busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  // Holds sd_ack for n edges, then walks through REL back to IDLE.
  task automatic applyStimulus(input int n, input string tag);
    sd_bus.sd_ack = 1'b1;
    repeat (n) tick();
    sd_bus.sd_ack = 1'b0;
    tick();
    checkOutput({tag, "_rel_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_rel_ack"}, 32'(ch_ack), 32'd0);
    tick();
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ack_cnt;
    int ack_bad;
    int wr_cnt;
    int wr_bad;
    int din_bad;
    logic [7:0] exp_din;
    logic [1:0] fair_order [5];

    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    ch_en        = 4'h0;
    ch_lba       = '0;
    ch_sz        = '0;
    ch_rd        = 4'h0;
    ch_wr        = 4'h0;
    ch_buff_din  = '0;
    sd_bus.sd_ack     = 1'b0;
    sd_bus.sd_buff_wr = 1'b0;

    #2;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_rd", 32'(sd_bus.sd_rd), 32'd0);
    checkOutput("rst_wr", 32'(sd_bus.sd_wr), 32'd0);
    checkOutput("rst_lba", sd_bus.sd_lba, 32'd0);
    checkOutput("rst_sz", 32'(sd_bus.sd_sz), 32'd0);
    checkOutput("rst_ack", 32'(ch_ack), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    ch_en   = 4'hF;
    tick();

    // Single read on channel 1 with a 10-cycle ack.
    ch_lba[63:32] = 32'h123;
    ch_sz[11:6]   = 6'd5;
    ch_rd[1]      = 1'b1;
    #1;
    checkOutput("rd_latency", 32'(sd_bus.sd_rd), 32'd0);
    tick();
    checkOutput("rd_strobe", 32'(sd_bus.sd_rd), 32'd1);
    checkOutput("rd_no_wr", 32'(sd_bus.sd_wr), 32'd0);
    checkOutput("rd_lba", sd_bus.sd_lba, 32'h123);
    checkOutput("rd_sz", 32'(sd_bus.sd_sz), 32'd5);
    checkOutput("rd_grant", 32'(grant), 32'd1);
    checkOutput("rd_busy", 32'(busy), 32'd1);
    sd_bus.sd_ack = 1'b1;
    ch_rd[1]      = 1'b0;
    ack_cnt = 0;
    ack_bad = 0;
    for (int j = 0; j < 10; j++) begin
      #1;
      if (ch_ack == 4'b0010) ack_cnt++;
      else ack_bad++;
      tick();
      if (j == 0) checkOutput("rd_strobe_drop", 32'(sd_bus.sd_rd), 32'd0);
    end
    sd_bus.sd_ack = 1'b0;
    #1;
    checkOutput("rd_ack_cycles", 32'(ack_cnt), 32'd10);
    checkOutput("rd_ack_others", 32'(ack_bad), 32'd0);
    checkOutput("rd_ack_fall", 32'(ch_ack), 32'd0);
    tick();
    checkOutput("rd_rel_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("rd_idle_busy", 32'(busy), 32'd0);
    checkOutput("rd_grant_kept", 32'(grant), 32'd1);

    // Shifted write on channel 2, then 512 buffer strobes routed to it.
    ch_lba[95:64] = 32'h40;
    ch_wr[2]      = 1'b1;
    tick();
    checkOutput("sh_wr", 32'(sd_bus.sd_wr), 32'd1);
    checkOutput("sh_no_rd", 32'(sd_bus.sd_rd), 32'd0);
    checkOutput("sh_lba", sd_bus.sd_lba, 32'h80);
    checkOutput("sh_grant", 32'(grant), 32'd2);
    sd_bus.sd_ack = 1'b1;
    ch_wr[2]      = 1'b0;
    wr_cnt  = 0;
    wr_bad  = 0;
    din_bad = 0;
    for (int j = 0; j < 1024; j++) begin
      sd_bus.sd_buff_wr = (j % 2 == 0);
      ch_buff_din = {8'(j ^ 8'h33), 8'(j + 7), 8'(j * 5), 8'(~j)};
      exp_din = 8'(j + 7);
      #1;
      if (sd_bus.sd_buff_wr) begin
        if (ch_buff_wr == 4'b0100) wr_cnt++;
        else wr_bad++;
      end else if (ch_buff_wr != 4'b0000) begin
        wr_bad++;
      end
      if (sd_bus.sd_buff_din != exp_din) din_bad++;
      tick();
    end
    checkOutput("rt_pulse_count", 32'(wr_cnt), 32'd512);
    checkOutput("rt_other_bits", 32'(wr_bad), 32'd0);
    checkOutput("rt_buff_din", 32'(din_bad), 32'd0);
    sd_bus.sd_buff_wr = 1'b0;
    sd_bus.sd_ack     = 1'b0;
    tick();
    checkOutput("rt_rel_lba_held", sd_bus.sd_lba, 32'h80);
    sd_bus.sd_ack = 1'b1;
    #1;
    checkOutput("rt_rel_ack_ignored", 32'(ch_ack), 32'd0);
    sd_bus.sd_ack = 1'b0;
    tick();
    checkOutput("rt_idle_busy", 32'(busy), 32'd0);
    checkOutput("rt_idle_din", 32'(sd_bus.sd_buff_din), 32'd0);

    sd_bus.sd_ack = 1'b1;
    #1;
    checkOutput("idle_ack_ignored", 32'(ch_ack), 32'd0);
    tick();
    checkOutput("idle_ack_busy", 32'(busy), 32'd0);
    sd_bus.sd_ack = 1'b0;

    // Abort on channel 3; last grant stays 2 so channel 3 beats channel 0 next.
    ch_rd[3] = 1'b1;
    tick();
    checkOutput("ab_grant", 32'(grant), 32'd3);
    checkOutput("ab_strobe", 32'(sd_bus.sd_rd), 32'd1);
    ch_rd[3] = 1'b0;
    tick();
    checkOutput("ab_strobe_drop", 32'(sd_bus.sd_rd), 32'd0);
    checkOutput("ab_idle", 32'(busy), 32'd0);
    ch_rd = 4'b1001;
    tick();
    checkOutput("ab_next_grant", 32'(grant), 32'd3);
    applyStimulus(3, "ab");

    // All channels request read and write together: reads, in rotating order.
    fair_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ch_rd = 4'hF;
    ch_wr = 4'hF;
    for (int n = 0; n < 5; n++) begin
      tick();
      checkOutput($sformatf("fair_grant_%0d", n), 32'(grant), 32'(fair_order[n]));
      checkOutput($sformatf("fair_rd_%0d", n), 32'(sd_bus.sd_rd), 32'd1);
      checkOutput($sformatf("fair_wr_%0d", n), 32'(sd_bus.sd_wr), 32'd0);
      applyStimulus(2, $sformatf("fair_%0d", n));
    end
    ch_rd = 4'h0;
    ch_wr = 4'h0;

    // Disabled channel is never granted; disabling mid-transfer does not abort.
    ch_en = 4'b1011;
    ch_rd = 4'b0100;
    repeat (2) tick();
    checkOutput("dis_not_granted", 32'(busy), 32'd0);
    ch_en = 4'hF;
    tick();
    checkOutput("en_grant", 32'(grant), 32'd2);
    sd_bus.sd_ack = 1'b1;
    tick();
    ch_en = 4'b1011;
    ch_rd = 4'h0;
    #1;
    checkOutput("dis_mid_ack", 32'(ch_ack), 32'b0100);
    tick();
    checkOutput("dis_mid_busy", 32'(busy), 32'd1);

    // Reset in the middle of the transfer while sd_ack is high.
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_rd", 32'(sd_bus.sd_rd), 32'd0);
    checkOutput("mid_rst_ack", 32'(ch_ack), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_grant", 32'(grant), 32'd0);
    tick();
    sd_bus.sd_ack = 1'b0;
    reset_n = 1'b1;
    ch_en   = 4'hF;
    ch_rd   = 4'b0101;
    tick();
    checkOutput("post_rst_grant", 32'(grant), 32'd0);
    checkOutput("post_rst_rd", 32'(sd_bus.sd_rd), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
